// File: rtl/pool2d_multichannel.sv
// Multi-channel 2-D pooling engine: loads a CHANNELS x IMG_H x IMG_W signed frame into RAM,
// pools each channel (max or average), and serves the results on a registered read port.
module pool2d_multichannel #(
  parameter int INT_W    = 10,
  parameter int FRAC_W   = 10,
  parameter int IMG_W    = 4,
  parameter int IMG_H    = 4,
  parameter int CHANNELS = 1,
  parameter int POOL_W   = 2,
  parameter int POOL_H   = 2,
  parameter int STRIDE   = 2,
  parameter int MODE     = 0,
  localparam int DW      = INT_W + FRAC_W,
  localparam int OUT_W   = (IMG_W - POOL_W) / STRIDE + 1,
  localparam int OUT_H   = (IMG_H - POOL_H) / STRIDE + 1,
  localparam int N_OUT   = CHANNELS * OUT_H * OUT_W,
  localparam int RAW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  input  logic [RAW-1:0]       rd_addr,
  output logic signed [DW-1:0] rd_data,
  output logic                 busy,
  output logic                 done
);

  localparam int N_IN = CHANNELS * IMG_H * IMG_W;
  localparam int IAW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SH   = $clog2(POOL_W * POOL_H);
  localparam int ACCW = DW + SH;

  typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_ACC, S_WRITE, S_FINISH} state_t;

  state_t                 state_q;
  int                     ld_q, c_q, oy_q, ox_q, ky_q, kx_q;
  logic                   in_ready_q, busy_q, done_q;
  logic signed [DW-1:0]   rd_data_q;
  logic signed [DW-1:0]   elem_q;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [IAW-1:0]         in_addr_d;
  logic [RAW-1:0]         out_addr_d;
  logic                   accept;

  logic signed [DW-1:0] in_mem  [0:(1<<IAW)-1];
  logic signed [DW-1:0] out_mem [0:(1<<RAW)-1];

  function automatic logic signed [ACCW-1:0] widen(input logic signed [DW-1:0] x);
    return ACCW'(x);
  endfunction

  function automatic logic signed [ACCW-1:0] pool_step(input logic signed [ACCW-1:0] acc,
                                                       input logic signed [DW-1:0]   x,
                                                       input logic                   first);
    logic signed [ACCW-1:0] xw;
    xw = widen(x);
    if (first)     return xw;
    if (MODE == 1) return acc + xw;
    return (xw > acc) ? xw : acc;
  endfunction

  // Average divides by the power-of-two window size: floor toward -inf, wrap instead of saturating.
  function automatic logic signed [DW-1:0] finalize(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] sh;
    if (MODE == 1) sh = acc >>> SH;
    else           sh = acc;
    return $signed(sh[DW-1:0]);
  endfunction

  always_comb begin
    accept     = in_valid & in_ready_q;
    in_addr_d  = IAW'(c_q * IMG_H * IMG_W + (oy_q * STRIDE + ky_q) * IMG_W + ox_q * STRIDE + kx_q);
    out_addr_d = RAW'(c_q * OUT_H * OUT_W + oy_q * OUT_W + ox_q);
    acc_d      = pool_step(acc_q, elem_q, (kx_q == 0) && (ky_q == 0));
  end

  // Datapath storage: no reset, contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && accept) in_mem[IAW'(ld_q)] <= in_data;
    if (state_q == S_ISSUE)          elem_q <= in_mem[in_addr_d];
    if (state_q == S_ACC)            acc_q <= acc_d;
    if (state_q == S_WRITE)          out_mem[out_addr_d] <= finalize(acc_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      ld_q       <= 0;
      c_q        <= 0;
      oy_q       <= 0;
      ox_q       <= 0;
      ky_q       <= 0;
      kx_q       <= 0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (done_q) rd_data_q <= out_mem[rd_addr];
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            done_q <= 1'b0;
            if (ld_q == N_IN - 1) begin
              ld_q       <= 0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              c_q        <= 0;
              oy_q       <= 0;
              ox_q       <= 0;
              ky_q       <= 0;
              kx_q       <= 0;
              state_q    <= S_ISSUE;
            end else begin
              ld_q <= ld_q + 1;
            end
          end
        end
        S_ISSUE: state_q <= S_ACC;
        S_ACC: begin
          if (kx_q == POOL_W - 1) begin
            kx_q <= 0;
            if (ky_q == POOL_H - 1) begin
              ky_q    <= 0;
              state_q <= S_WRITE;
            end else begin
              ky_q    <= ky_q + 1;
              state_q <= S_ISSUE;
            end
          end else begin
            kx_q    <= kx_q + 1;
            state_q <= S_ISSUE;
          end
        end
        S_WRITE: begin
          state_q <= S_ISSUE;
          if (ox_q == OUT_W - 1) begin
            ox_q <= 0;
            if (oy_q == OUT_H - 1) begin
              oy_q <= 0;
              if (c_q == CHANNELS - 1) begin
                c_q     <= 0;
                state_q <= S_FINISH;
              end else begin
                c_q <= c_q + 1;
              end
            end else begin
              oy_q <= oy_q + 1;
            end
          end else begin
            ox_q <= ox_q + 1;
          end
        end
        S_FINISH: begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
          ld_q       <= 0;
          state_q    <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_pool2d_multichannel.sv
// Bench for pool2d_multichannel: four parameterisations share one clock; readback results are
// queued as expectations and checked by an independent monitor one cycle after each read.
module tb_pool2d_multichannel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [3:0]        vld;
  logic signed [19:0] din;
  logic [3:0]        ra;
  wire  [3:0]        rdy, bsy, dn;
  wire  signed [19:0] rd0, rd1, rd2, rd3;

  pool2d_multichannel u0 (
    .clk(clk), .reset(rst), .in_valid(vld[0]), .in_data(din), .in_ready(rdy[0]),
    .rd_addr(ra[1:0]), .rd_data(rd0), .busy(bsy[0]), .done(dn[0]));

  pool2d_multichannel #(.CHANNELS(2)) u1 (
    .clk(clk), .reset(rst), .in_valid(vld[1]), .in_data(din), .in_ready(rdy[1]),
    .rd_addr(ra[2:0]), .rd_data(rd1), .busy(bsy[1]), .done(dn[1]));

  pool2d_multichannel #(.MODE(1)) u2 (
    .clk(clk), .reset(rst), .in_valid(vld[2]), .in_data(din), .in_ready(rdy[2]),
    .rd_addr(ra[1:0]), .rd_data(rd2), .busy(bsy[2]), .done(dn[2]));

  pool2d_multichannel #(.IMG_W(5), .IMG_H(5), .POOL_W(3), .POOL_H(3), .STRIDE(1)) u3 (
    .clk(clk), .reset(rst), .in_valid(vld[3]), .in_data(din), .in_ready(rdy[3]),
    .rd_addr(ra[3:0]), .rd_data(rd3), .busy(bsy[3]), .done(dn[3]));

  typedef struct {int inst; int addr; int exp;} rd_t;
  rd_t sbq[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic rd_en = 1'b0, rd_en_d = 1'b0;
  int   sel = 0, sel_d = 0;
  logic signed [19:0] img [0:63];

  function automatic logic signed [31:0] rd_of(int i);
    case (i)
      0: return 32'(rd0);
      1: return 32'(rd1);
      2: return 32'(rd2);
      3: return 32'(rd3);
      default: return 'x;
    endcase
  endfunction

  always @(posedge clk) begin
    rd_en_d <= rd_en;
    sel_d   <= sel;
  end

  // Monitor: every read issued one cycle earlier is compared against the queue head.
  always @(negedge clk) begin
    rd_t e;
    logic signed [31:0] got;
    if (rd_en_d) begin
      n_vec++;
      got = rd_of(sel_d);
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: u%0d got %0d, no expectation queued", sel_d, got);
      end else begin
        e = sbq.pop_front();
        if (got !== 32'(e.exp)) begin
          n_err++;
          $display("FAIL rd u%0d[%0d]: got %0d, expected %0d", e.inst, e.addr, got, e.exp);
        end
      end
    end
  end

  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic load(int inst, int first, int n);
    for (int i = first; i < n; i++) begin
      vld[inst] = 1'b1;
      din = img[i];
      @(posedge clk); #1;
    end
    vld[inst] = 1'b0;
  endtask

  task automatic wait_done(int inst, int limit, output int cyc);
    cyc = 0;
    while (!dn[inst] && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!dn[inst]) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout u%0d: done=0 after %0d cycles", inst, cyc);
    end
  endtask

  task automatic rd(int inst, int addr, int exp);
    rd_t e;
    e.inst = inst; e.addr = addr; e.exp = exp;
    ra    = 4'(addr);
    sel   = inst;
    rd_en = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  function automatic int max3x3(int oy, int ox);
    int m;
    m = int'(img[oy * 5 + ox]);
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        if (int'(img[(oy + ky) * 5 + ox + kx]) > m) m = int'(img[(oy + ky) * 5 + ox + kx]);
    return m;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int exp_a [4];
    int exp_b [8];
    int exp_c [4];
    rst = 1'b1; vld = '0; din = '0; ra = '0;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chkb($sformatf("reset u%0d in_ready", i), rdy[i], 1'b1);
      chkb($sformatf("reset u%0d busy", i), bsy[i], 1'b0);
      chkb($sformatf("reset u%0d done", i), dn[i], 1'b0);
      chk($sformatf("reset u%0d rd_data", i), rd_of(i), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Two channels, second is the negated first: signed max must pick values nearest zero.
    for (int i = 0; i < 16; i++) begin
      img[i]      = 20'(i * 1024);
      img[16 + i] = 20'(-i * 1024);
    end
    load(1, 0, 32);
    wait_done(1, 200, cyc);
    chk("u1 done latency", cyc, 1 + 8 * 9);
    exp_b = '{5, 7, 13, 15, 0, -2, -8, -10};
    for (int a = 0; a < 8; a++) rd(1, a, exp_b[a] * 1024);

    // Average mode: exact fraction, floor of -1 LSB, positive floor, negative floor.
    exp_c = '{-384, -1, 3, -6};
    img[0]  = -20'sd1024; img[1]  = -20'sd2048; img[2]  = -20'sd1; img[3]  = 20'sd0;
    img[4]  =  20'sd1024; img[5]  =  20'sd512;  img[6]  = 20'sd0;  img[7]  = 20'sd0;
    img[8]  =  20'sd3;    img[9]  =  20'sd3;    img[10] = -20'sd5; img[11] = -20'sd5;
    img[12] =  20'sd3;    img[13] =  20'sd4;    img[14] = -20'sd5; img[15] = -20'sd6;
    load(2, 0, 16);
    wait_done(2, 100, cyc);
    for (int a = 0; a < 4; a++) rd(2, a, exp_c[a]);

    // 5x5 image, 3x3 window, stride 1: overlapping windows, 9 results.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r * 5 + c] = 20'((((r * 7 + c * 3) % 11) - 5) * 256);
    load(3, 0, 25);
    wait_done(3, 400, cyc);
    chk("u3 done latency", cyc, 1 + 9 * 19);
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++)
        rd(3, oy * 3 + ox, max3x3(oy, ox));

    // Reversed ramp first, so the next frame visibly replaces these results.
    for (int i = 0; i < 16; i++) img[i] = 20'((15 - i) * 1024);
    load(0, 0, 16);
    wait_done(0, 100, cyc);
    exp_a = '{15, 13, 7, 5};
    for (int a = 0; a < 4; a++) rd(0, a, exp_a[a] * 1024);

    // New frame while done=1, with junk beats offered throughout compute.
    for (int i = 0; i < 16; i++) img[i] = 20'(i * 1024);
    chkb("u0 done before new frame", dn[0], 1'b1);
    load(0, 0, 1);
    chkb("u0 done falls on first beat", dn[0], 1'b0);
    load(0, 1, 16);
    chkb("u0 busy after last beat", bsy[0], 1'b1);
    chkb("u0 in_ready after last beat", rdy[0], 1'b0);
    cyc = 0;
    vld[0] = 1'b1;
    while (!dn[0] && cyc < 100) begin
      din = 20'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (!dn[0] && (cyc % 9) == 5) chkb("u0 in_ready during compute", rdy[0], 1'b0);
    end
    vld[0] = 1'b0;
    chk("u0 done latency", cyc, 1 + 4 * 9);
    exp_a = '{5, 7, 13, 15};
    for (int a = 0; a < 4; a++) rd(0, a, exp_a[a] * 1024);

    // Reset during ACC of window 2, then reload the ramp frame.
    for (int i = 0; i < 16; i++) img[i] = 20'((15 - i) * 1024);
    load(0, 0, 16);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chkb("u0 done after mid reset", dn[0], 1'b0);
    chkb("u0 in_ready after mid reset", rdy[0], 1'b1);
    chkb("u0 busy after mid reset", bsy[0], 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (40) @(posedge clk);
    #1;
    chkb("u0 stays idle after reset", dn[0], 1'b0);
    for (int i = 0; i < 16; i++) img[i] = 20'(i * 1024);
    load(0, 0, 16);
    wait_done(0, 100, cyc);
    chk("u0 done latency after reset", cyc, 1 + 4 * 9);
    for (int a = 0; a < 4; a++) rd(0, a, exp_a[a] * 1024);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
